// File: rtl/video_timing_ctrl.sv
// Raster timing generator for a DVI/TMDS encoder: syncs, blank, pixel coordinates and
// line/frame pulses. Output starts and stops only on frame boundaries.
module video_timing_ctrl #(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   COORD_W   = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               hsync,
   output logic               vsync,
   output logic               blank,
   output logic               line_start,
   output logic               frame_start,
   output logic               running
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   // Region bounds as inclusive last-values so a sync ending exactly at TOTAL cannot wrap.
   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] HA_LAST  = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] VA_LAST  = COORD_W'(V_ACTIVE - 1);
   localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FRONT);
   localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FRONT);
   localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, nxt_state;
   logic [COORD_W-1:0] nxt_x, nxt_y;
   logic               nxt_run;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      nxt_state = state;
      nxt_x     = x;
      nxt_y     = y;
      case (state)
         IDLE: begin
            nxt_x = '0;
            nxt_y = '0;
            if (enable) nxt_state = RUN;
         end
         RUN: begin
            if (x == H_LAST) begin
               nxt_x = '0;
               if (y == V_LAST) begin
                  nxt_y = '0;
                  if (!enable) nxt_state = IDLE;
               end else begin
                  nxt_y = y + 1'b1;
               end
            end else begin
               nxt_x = x + 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   assign nxt_run = (nxt_state == RUN);

   // Outputs are decoded from the next coordinates so every registered output describes
   // the same pixel as x/y in the same cycle.
   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         blank       <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         running     <= 1'b0;
      end else begin
         state       <= nxt_state;
         x           <= nxt_x;
         y           <= nxt_y;
         hsync       <= (nxt_run && nxt_x >= HS_FIRST && nxt_x <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= (nxt_run && nxt_y >= VS_FIRST && nxt_y <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
         blank       <= !nxt_run || (nxt_x > HA_LAST) || (nxt_y > VA_LAST);
         line_start  <= nxt_run && (nxt_x == '0);
         frame_start <= nxt_run && (nxt_x == '0) && (nxt_y == '0);
         running     <= nxt_run;
      end
   end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl on a reduced 15x10 raster: per-cycle reference
// model scoreboard, a table of spot checks over one captured frame, and start/stop/reset sequences.
module tb_video_timing_ctrl;

   localparam int   HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int   VA = 6, VF = 1, VS = 2, VB = 1;
   localparam int   HT = HA + HF + HS + HB;   // 15
   localparam int   VT = VA + VF + VS + VB;   // 10
   localparam int   FRAME = HT * VT;          // 150
   localparam int   CW = 5;
   localparam logic HPOL = 1'b0, VPOL = 1'b0;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [CW-1:0] x, y;
   logic          hsync, vsync, blank, line_start, frame_start, running;

   video_timing_ctrl #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .COORD_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .x(x), .y(y), .hsync(hsync), .vsync(vsync), .blank(blank),
      .line_start(line_start), .frame_start(frame_start), .running(running)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic hs, vs, bl, ls, fs, run;
   } out_t;

   typedef struct {
      int   k;
      out_t exp;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   out_t exp_q[$];
   out_t last;
   out_t cap[FRAME];
   vec_t vecs[$];

   // Reference model state
   logic m_run = 1'b0;
   int   m_h = 0, m_v = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input out_t act, input out_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b run=%b expected x=%0d y=%0d hs=%b vs=%b bl=%b ls=%b fs=%b run=%b",
                  name, act.x, act.y, act.hs, act.vs, act.bl, act.ls, act.fs, act.run,
                  exp.x, exp.y, exp.hs, exp.vs, exp.bl, exp.ls, exp.fs, exp.run);
      end
   endtask

   function automatic out_t sample();
      out_t o;
      o.x = x; o.y = y; o.hs = hsync; o.vs = vsync; o.bl = blank;
      o.ls = line_start; o.fs = frame_start; o.run = running;
      return o;
   endfunction

   function automatic out_t mk(input int xx, input int yy, input logic hs, input logic vs,
                               input logic bl, input logic ls, input logic fs, input logic run);
      out_t o;
      o.x = CW'(xx); o.y = CW'(yy); o.hs = hs; o.vs = vs; o.bl = bl;
      o.ls = ls; o.fs = fs; o.run = run;
      return o;
   endfunction

   function automatic out_t model_out();
      logic hs_on, vs_on;
      hs_on = m_run && (m_h >= HA + HF) && (m_h < HA + HF + HS);
      vs_on = m_run && (m_v >= VA + VF) && (m_v < VA + VF + VS);
      return mk(m_h, m_v, hs_on ? HPOL : ~HPOL, vs_on ? VPOL : ~VPOL,
                !m_run || m_h >= HA || m_v >= VA,
                m_run && m_h == 0, m_run && m_h == 0 && m_v == 0, m_run);
   endfunction

   task automatic model_step(input logic en);
      if (!m_run) begin
         if (en) m_run = 1'b1;
         m_h = 0; m_v = 0;
      end else if (m_h == HT - 1) begin
         m_h = 0;
         if (m_v == VT - 1) begin
            m_v = 0;
            if (!en) m_run = 1'b0;
         end else begin
            m_v++;
         end
      end else begin
         m_h++;
      end
   endtask

   // One clock: drive enable, queue the model's prediction, then compare after the edge.
   task automatic step(input logic en, input string tag);
      out_t e;
      enable = en;
      model_step(en);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      last = sample();
      e = exp_q.pop_front();
      check_out(tag, last, e);
   endtask

   initial begin
      out_t idle_o;
      int   cnt, cnt2;
      idle_o = mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Spot checks at frame offset k from the first pixel (x = k%15, y = k/15)
      vecs.push_back('{0,   mk(0,  0, 1, 1, 0, 1, 1, 1)});
      vecs.push_back('{7,   mk(7,  0, 1, 1, 0, 0, 0, 1)});
      vecs.push_back('{8,   mk(8,  0, 1, 1, 1, 0, 0, 1)});
      vecs.push_back('{10,  mk(10, 0, 0, 1, 1, 0, 0, 1)});
      vecs.push_back('{12,  mk(12, 0, 0, 1, 1, 0, 0, 1)});
      vecs.push_back('{13,  mk(13, 0, 1, 1, 1, 0, 0, 1)});
      vecs.push_back('{15,  mk(0,  1, 1, 1, 0, 1, 0, 1)});
      vecs.push_back('{90,  mk(0,  6, 1, 1, 1, 1, 0, 1)});
      vecs.push_back('{105, mk(0,  7, 1, 0, 1, 1, 0, 1)});
      vecs.push_back('{134, mk(14, 8, 1, 0, 1, 0, 0, 1)});
      vecs.push_back('{135, mk(0,  9, 1, 1, 1, 1, 0, 1)});
      vecs.push_back('{149, mk(14, 9, 1, 1, 1, 0, 0, 1)});

      reset = 1'b1;
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_out("reset_state", sample(), idle_o);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, "idle_hold");

      // Start and capture one full frame
      step(1'b1, "start");
      check("start_frame_start", int'(last.fs), 1);
      cap[0] = last;
      for (int k = 1; k < FRAME; k++) begin
         step(1'b1, "frame1");
         cap[k] = last;
      end
      step(1'b1, "frame2_start");
      check("frame_period", int'(last.fs), 1);

      foreach (vecs[i]) check_out($sformatf("vec_k%0d", vecs[i].k), cap[vecs[i].k], vecs[i].exp);

      cnt = 0;
      for (int k = 0; k < FRAME; k++) cnt += int'(cap[k].ls);
      check("line_start_count", cnt, VT);
      cnt = 0;
      for (int k = 0; k < FRAME; k++) if (cap[k].ls && cap[k].x != 0) cnt++;
      check("line_start_at_x0", cnt, 0);
      cnt = 0;
      for (int k = 0; k < HT; k++) cnt += int'(!cap[k].hs);
      check("hsync_low_line0", cnt, HS);
      cnt = 0;
      for (int k = 0; k < FRAME; k++) cnt += int'(!cap[k].vs);
      check("vsync_low_cycles", cnt, VS * HT);
      cnt = 0;
      for (int k = 0; k < FRAME; k++) cnt += int'(cap[k].bl);
      check("blank_cycles", cnt, FRAME - HA * VA);

      // Frames 2 and 3 back to back: no idle cycle, one more frame_start
      cnt = 0; cnt2 = 0;
      for (int i = 0; i < 2 * FRAME - 1; i++) begin
         step(1'b1, "frames23");
         cnt  += int'(last.fs);
         cnt2 += int'(!last.run);
      end
      check("frame3_start_seen", cnt, 1);
      check("no_gap_cycles", cnt2, 0);

      // Stop: drop enable mid-frame, frame completes, then idle
      step(1'b1, "frame4_start");
      for (int i = 0; i < 2 * HT + 10; i++) step(1'b1, "frame4");
      check("stop_point_x", int'(last.x), 10);
      check("stop_point_y", int'(last.y), 2);
      cnt = 0;
      for (int i = 0; i < FRAME - 1 - (2 * HT + 10); i++) begin
         step(1'b0, "frame4_tail");
         cnt += int'(!last.run);
      end
      check("tail_still_running", cnt, 0);
      check("last_pixel_x", int'(last.x), HT - 1);
      check("last_pixel_y", int'(last.y), VT - 1);
      step(1'b0, "stopped");
      check_out("stopped_idle", last, idle_o);
      for (int i = 0; i < 4; i++) step(1'b0, "stopped_hold");
      step(1'b1, "restart");
      check("restart_frame_start", int'(last.fs), 1);

      // Asynchronous reset mid-frame, between clock edges
      for (int i = 0; i < 3 * HT + 5; i++) step(1'b1, "pre_reset");
      check("reset_point_x", int'(last.x), 5);
      check("reset_point_y", int'(last.y), 3);
      #2;
      reset = 1'b1;
      #1;
      check_out("async_reset_clear", sample(), idle_o);
      m_run = 1'b0; m_h = 0; m_v = 0;
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, "post_reset_idle");
      step(1'b1, "post_reset_start");
      check("post_reset_frame_start", int'(last.fs), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
